// File: rtl/dvs_event_fifo.sv
// Elastic FWFT event buffer between the DVS AER receiver and the RAVENS consumer.
// Drops events on overflow and keeps drop and peak-occupancy diagnostics.
package dvs_ravens_pkg;
  localparam int DVS_X_ADDR_BITS   = 9;
  localparam int DVS_Y_ADDR_BITS   = 9;
  localparam int TIMESTAMP_US_BITS = 32;
endpackage

module dvs_event_fifo
  import dvs_ravens_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int DROP_CNT_BITS = 16,
  parameter int X_BITS        = DVS_X_ADDR_BITS,
  parameter int Y_BITS        = DVS_Y_ADDR_BITS,
  parameter int TS_BITS       = TIMESTAMP_US_BITS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [X_BITS-1:0]          in_x,
  input  logic [Y_BITS-1:0]          in_y,
  input  logic [TS_BITS-1:0]         in_ts,
  input  logic                       in_pol,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [X_BITS-1:0]          out_x,
  output logic [Y_BITS-1:0]          out_y,
  output logic [TS_BITS-1:0]         out_ts,
  output logic                       out_pol,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     peak_count,
  output logic [DROP_CNT_BITS-1:0]   drop_count,
  output logic                       overflow,
  input  logic                       clear_stats
);

  localparam int PTR_BITS = $clog2(DEPTH);
  localparam int CNT_BITS = PTR_BITS + 1;
  localparam logic [CNT_BITS-1:0]      FULL_CNT = CNT_BITS'(DEPTH);
  localparam logic [DROP_CNT_BITS-1:0] DROP_MAX = '1;

  typedef struct packed {
    logic [X_BITS-1:0]  x;
    logic [Y_BITS-1:0]  y;
    logic [TS_BITS-1:0] ts;
    logic               pol;
  } event_t;

  event_t                mem [DEPTH];
  event_t                head;
  logic [PTR_BITS-1:0]   wr_ptr;
  logic [PTR_BITS-1:0]   rd_ptr;
  logic [CNT_BITS-1:0]   count_next;
  logic [CNT_BITS-1:0]   peak_next;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  // A full buffer still accepts an event when the head leaves in the same cycle.
  assign push      = in_valid & ((count != FULL_CNT) | pop);
  assign drop      = in_valid & ~push;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_comb begin
    peak_next = peak_count;
    if (clear_stats || (count_next > peak_count)) begin
      peak_next = count_next;
    end
  end

  // NOTE: the storage array has no reset; out_valid gates every read, so stale
  // contents are never visible, and leaving it unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= event_t'{x: in_x, y: in_y, ts: in_ts, pol: in_pol};
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      peak_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count      <= count_next;
      peak_count <= peak_next;
    end
  end

  // A drop coinciding with clear_stats is counted after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
      overflow   <= 1'b0;
    end else if (clear_stats) begin
      drop_count <= drop ? DROP_CNT_BITS'(1) : '0;
      overflow   <= drop;
    end else if (drop) begin
      if (drop_count != DROP_MAX) drop_count <= drop_count + 1'b1;
      overflow <= 1'b1;
    end
  end

  assign head    = mem[rd_ptr];
  assign out_x   = out_valid ? head.x   : '0;
  assign out_y   = out_valid ? head.y   : '0;
  assign out_ts  = out_valid ? head.ts  : '0;
  assign out_pol = out_valid ? head.pol : 1'b0;

endmodule

// File: tb/tb_dvs_event_fifo.sv
// Randomized scoreboard bench for dvs_event_fifo against a queue-based model of
// the buffer occupancy, drop counter and peak statistics.
module tb_dvs_event_fifo;
  localparam int DEPTH = 16;
  localparam int DCB   = 4;
  localparam int XB    = 9;
  localparam int YB    = 9;
  localparam int TSB   = 32;
  localparam int DMAX  = (1 << DCB) - 1;

  typedef struct {
    logic [XB-1:0]  x;
    logic [YB-1:0]  y;
    logic [TSB-1:0] ts;
    logic           pol;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_pol = 1'b0, out_ready = 1'b0, clear_stats = 1'b0;
  logic [XB-1:0]  in_x = '0;
  logic [YB-1:0]  in_y = '0;
  logic [TSB-1:0] in_ts = '0;
  logic out_valid, out_pol, overflow;
  logic [XB-1:0]  out_x;
  logic [YB-1:0]  out_y;
  logic [TSB-1:0] out_ts;
  logic [$clog2(DEPTH):0] count, peak_count;
  logic [DCB-1:0] drop_count;

  dvs_event_fifo #(.DEPTH(DEPTH), .DROP_CNT_BITS(DCB), .X_BITS(XB), .Y_BITS(YB), .TS_BITS(TSB)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_x(in_x), .in_y(in_y), .in_ts(in_ts), .in_pol(in_pol),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_ts(out_ts), .out_pol(out_pol),
    .count(count), .peak_count(peak_count), .drop_count(drop_count),
    .overflow(overflow), .clear_stats(clear_stats)
  );

  always #5 clk = ~clk;

  int  total = 0;
  int  bad = 0;
  ev_t sb[$];
  int  m_count = 0, m_peak = 0, m_drop = 0;
  bit  m_ovf = 1'b0;
  int  ev_seq = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ev_t mk_ev();
    ev_t e;
    e.x   = XB'(ev_seq);
    e.y   = YB'($urandom);
    e.ts  = $urandom;
    e.pol = 1'($urandom);
    ev_seq++;
    return e;
  endfunction

  // Called at posedge+1: drive one cycle of inputs, then apply the model's
  // view of what the next edge does.
  task automatic step(input bit iv, input ev_t e, input bit rdy, input bit clr);
    bit pop, push, drop;
    int nc;
    in_valid = iv; in_x = e.x; in_y = e.y; in_ts = e.ts; in_pol = e.pol;
    out_ready = rdy; clear_stats = clr;
    pop  = (m_count > 0) && rdy;
    push = iv && ((m_count < DEPTH) || pop);
    drop = iv && !push;
    nc   = m_count + int'(push) - int'(pop);
    @(posedge clk);
    #1;
    m_count = nc;
    if (push) sb.push_back(e);
    if (clr) begin
      m_drop = drop ? 1 : 0;
      m_ovf  = drop;
      m_peak = nc;
    end else begin
      if (drop) begin
        m_drop = (m_drop < DMAX) ? m_drop + 1 : DMAX;
        m_ovf  = 1'b1;
      end
      if (nc > m_peak) m_peak = nc;
    end
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; clear_stats = 1'b0;
  endtask

  task automatic drain();
    ev_t e;
    int guard = 0;
    while (m_count > 0 && guard < 100) begin
      e = mk_ev();
      step(1'b0, e, 1'b1, 1'b0);
      guard++;
    end
    check("drain_empty", 64'(m_count), 64'd0);
  endtask

  // Monitor: compares DUT state with the model and pops the scoreboard on
  // every accepted head.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      check("out_valid", 64'(out_valid), 64'(m_count != 0));
      check("count", 64'(count), 64'(m_count));
      check("peak_count", 64'(peak_count), 64'(m_peak));
      check("drop_count", 64'(drop_count), 64'(m_drop));
      check("overflow", 64'(overflow), 64'(m_ovf));
      if (!out_valid) begin
        check("idle_fields", {out_x, out_y, out_ts, out_pol}, 64'd0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'd0, 64'd1);
        end else begin
          e = sb.pop_front();
          check("out_x", 64'(out_x), 64'(e.x));
          check("out_y", 64'(out_y), 64'(e.y));
          check("out_ts", 64'(out_ts), 64'(e.ts));
          check("out_pol", 64'(out_pol), 64'(e.pol));
        end
      end
    end
  end

  initial begin
    ev_t e;
    int issued;
    int guard;

    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);

    // Single event with consumer stalled.
    e.x = 9'd5; e.y = 9'd7; e.ts = 32'd100; e.pol = 1'b1;
    step(1'b1, e, 1'b0, 1'b0);
    check("first_valid", 64'(out_valid), 64'd1);
    check("first_x", 64'(out_x), 64'd5);
    check("first_y", 64'(out_y), 64'd7);
    check("first_ts", 64'(out_ts), 64'd100);
    check("first_pol", 64'(out_pol), 64'd1);
    check("first_count", 64'(count), 64'd1);
    drain();

    // Overfill by one.
    for (int i = 0; i < 17; i++) step(1'b1, mk_ev(), 1'b0, 1'b0);
    check("fill_count", 64'(count), 64'd16);
    check("fill_drop", 64'(drop_count), 64'd1);
    check("fill_ovf", 64'(overflow), 64'd1);

    // Full with simultaneous push and pop.
    step(1'b1, mk_ev(), 1'b1, 1'b0);
    check("pp_count", 64'(count), 64'd16);
    check("pp_drop", 64'(drop_count), 64'd1);

    // Saturate the drop counter, then clear the stats while full.
    for (int i = 0; i < 20; i++) step(1'b1, mk_ev(), 1'b0, 1'b0);
    check("sat_drop", 64'(drop_count), 64'd15);
    step(1'b0, mk_ev(), 1'b0, 1'b1);
    check("clr_drop", 64'(drop_count), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_peak", 64'(peak_count), 64'd16);

    // Clear coinciding with a drop.
    step(1'b1, mk_ev(), 1'b0, 1'b1);
    check("clr_drop_wins", 64'(drop_count), 64'd1);
    check("clr_ovf_wins", 64'(overflow), 64'd1);
    drain();

    // Stream 40 events across pointer wrap, never offering into a full buffer.
    step(1'b0, mk_ev(), 1'b0, 1'b1);
    issued = 0;
    guard = 0;
    while (issued < 40 && guard < 1000) begin
      bit iv;
      iv = ($urandom_range(1) == 1) && (m_count < DEPTH);
      if (iv) issued++;
      step(iv, mk_ev(), ($urandom_range(3) != 0), 1'b0);
      guard++;
    end
    check("stream_issued", 64'(issued), 64'd40);
    drain();
    check("stream_drops", 64'(drop_count), 64'd0);

    // Asynchronous reset with 9 buffered events.
    for (int i = 0; i < 9; i++) step(1'b1, mk_ev(), 1'b0, 1'b0);
    check("pre_rst_count", 64'(count), 64'd9);
    idle_inputs();
    #2 rst_n = 1'b0;
    sb.delete();
    m_count = 0; m_peak = 0; m_drop = 0; m_ovf = 1'b0;
    #1;
    check("arst_valid", 64'(out_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_peak", 64'(peak_count), 64'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, mk_ev(), 1'b0, 1'b0);
    check("post_rst_count", 64'(count), 64'd1);
    drain();

    // Mixed random traffic with occasional clears and overflow pressure.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(9) < 7), mk_ev(), ($urandom_range(9) < 4),
           ($urandom_range(49) == 0));
    end
    drain();
    idle_inputs();
    @(posedge clk);
    #1;
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
